imem_uart_loader: RTL and testbench

//  Boot loader that fills instruction memory from the UART byte stream before the core runs.

---
 rtl/imem_uart_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART boot loader: SYNC, LEN (LSB first), LEN words (LSB first), XOR checksum -> imem writes; core held in reset until a frame checks out.
// Latency: imem write one cycle after a word's 4th byte, cpu_reset falls one cycle after a good CSUM byte. No backpressure.
module imem_uart_loader #(
  parameter int         DEPTH       = 64,
  parameter int         ADDR_W      = 6,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     len_lo;
  logic [15:0]    len;
  logic [23:0]    word_sr;
  logic [1:0]     byte_idx;
  logic [7:0]     csum_acc;
  logic [TW-1:0]  tmo_cnt;

  logic           in_frame;
  logic           tmo_hit;
  logic           sync_hit;
  logic           word_done;
  logic           frame_last;
  logic [15:0]    len_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    in_frame   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    // A byte landing on the final idle cycle beats the timeout.
    tmo_hit    = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    sync_hit   = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    len_rx     = {rx_data, len_lo};
    word_done  = (state == DATA) && rx_valid && (byte_idx == 2'd3);
    frame_last = word_done && ((words_loaded + 16'd1) == len);
    state_nxt  = state;

    case (state)
      IDLE: if (sync_hit) state_nxt = LEN0;
      LEN0: if (rx_valid) state_nxt = LEN1;
      LEN1: begin
        if (rx_valid) begin
          if (len_rx == 16'd0) begin
            state_nxt = CSUM;
          end else if (len_rx > 16'(DEPTH)) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: if (frame_last) state_nxt = CSUM;
      CSUM: begin
        if (rx_valid) begin
          state_nxt = (rx_data == csum_acc) ? DONE : ERR;
        end
      end
      DONE: if (boot_req) state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (tmo_hit) begin
      state_nxt = ERR;
    end
  end

  // Status flags are registered from the next state so cpu_reset never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 32'd0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 16'd0;
      len_lo       <= 8'd0;
      len          <= 16'd0;
      word_sr      <= 24'd0;
      byte_idx     <= 2'd0;
      csum_acc     <= 8'd0;
      tmo_cnt      <= '0;
    end else begin
      imem_we   <= 1'b0;
      cpu_reset <= (state_nxt != DONE);
      load_done <= (state_nxt == DONE);

      if (state_nxt == ERR) begin
        load_err <= 1'b1;
      end else if (sync_hit) begin
        load_err <= 1'b0;
      end

      if (!in_frame || rx_valid) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (sync_hit) begin
        csum_acc     <= 8'd0;
        byte_idx     <= 2'd0;
        words_loaded <= 16'd0;
      end

      if ((state == LEN0) && rx_valid) begin
        len_lo <= rx_data;
      end

      if ((state == LEN1) && rx_valid) begin
        len <= len_rx;
      end

      if ((state == DATA) && rx_valid) begin
        csum_acc <= csum_acc ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        word_sr  <= {rx_data, word_sr[23:8]};
      end

      // Word address follows the running word count; it restarts only with a new SYNC.
      if (word_done) begin
        imem_we      <= 1'b1;
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= {rx_data, word_sr};
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed timing sequences, a vector table and random frames against a frame-level model.
module tb_imem_uart_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              boot_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .boot_req(boot_req),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;
  int          overlap = 0;
  bit          noise_en = 1'b0;
  logic [31:0] act_mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [37:0] exp_wq [$];
  logic [31:0] words_q [$];

  typedef struct {
    int          len;
    logic [31:0] base;
    logic [31:0] step;
    bit          use_cs;
    logic [7:0]  cs;
    bit          e_done;
    bit          e_err;
    int          e_wl;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Write monitor: every imem write must match the model's next expected write.
  always @(negedge clk) begin : mon
    logic [37:0] e;
    if (imem_we === 1'b1) begin
      writes_seen++;
      if (cpu_reset !== 1'b1) overlap++;
      act_mem[imem_waddr] = imem_wdata;
      if (exp_wq.size() == 0) begin
        chk("unexpected_write_addr", 32'(imem_waddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_wq.pop_front();
        chk("write_addr", 32'(imem_waddr), 32'(e[37:32]));
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    boot_req = noise_en && ($urandom_range(0, 3) == 0);
    @(negedge clk);
    rx_valid = 1'b0;
    boot_req = 1'b0;
  endtask

  task automatic release_core(input string name);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    chk({name, "_rel_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({name, "_rel_load_done"}, 32'(load_done), 32'd0);
  endtask

  task automatic check_status(input string name, input bit e_done, input bit e_err, input int e_wl);
    chk({name, "_load_done"}, 32'(load_done), 32'(e_done));
    chk({name, "_load_err"}, 32'(load_err), 32'(e_err));
    chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!e_done));
    chk({name, "_words_loaded"}, 32'(words_loaded), 32'(e_wl));
  endtask

  // Frame-level model: builds the byte stream from words_q, predicts writes and outcome, then sends it.
  task automatic run_frame(input int len, input bit use_cs, input logic [7:0] cs_val,
                           input logic [7:0] cs_xor, input int gap_max,
                           output bit e_done, output bit e_err, output int e_wl);
    logic [7:0]  fr [$];
    logic [7:0]  x;
    logic [7:0]  sent;
    logic [31:0] w;
    fr = {};
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    fr.push_back(8'(len >> 8));
    if (len > DEPTH) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      e_wl   = 0;
    end else begin
      x = 8'd0;
      for (int i = 0; i < len; i++) begin
        w = words_q[i];
        for (int b = 0; b < 4; b++) begin
          fr.push_back(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
        exp_wq.push_back({6'(i), w});
        exp_mem[i] = w;
      end
      sent = use_cs ? cs_val : (x ^ cs_xor);
      fr.push_back(sent);
      e_done = (sent == x);
      e_err  = !e_done;
      e_wl   = len;
    end
    foreach (fr[k]) begin
      send_byte(fr[k]);
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
    end
    idle(2);
  endtask

  initial begin
    bit d_done, d_err, e_done, e_err;
    int d_wl, e_wl, w0, len;
    logic [7:0] cx;

    vecs[0] = '{2,  32'h0000_0013, 32'h0010_0080, 1'b0, 8'h00, 1'b1, 1'b0, 2};
    vecs[1] = '{2,  32'h0000_0013, 32'h0010_0080, 1'b1, 8'h81, 1'b0, 1'b1, 2};
    vecs[2] = '{2,  32'h0000_0013, 32'h0010_0080, 1'b0, 8'h00, 1'b1, 1'b0, 2};
    vecs[3] = '{65, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{0,  32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vecs[5] = '{1,  32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 8'h22, 1'b1, 1'b0, 1};
    vecs[6] = '{64, 32'h1000_0000, 32'h0101_0101, 1'b0, 8'h00, 1'b1, 1'b0, 64};
    vecs[7] = '{0,  32'h0000_0000, 32'h0000_0000, 1'b1, 8'h01, 1'b0, 1'b1, 0};
    vecs[8] = '{3,  32'h0BAD_F00D, 32'h1111_1111, 1'b1, 8'h5A, 1'b0, 1'b1, 3};

    for (int i = 0; i < DEPTH; i++) begin
      act_mem[i] = 32'hBAD0_0000 | 32'(i);
      exp_mem[i] = 32'hBAD0_0000 | 32'(i);
    end

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; boot_req = 1'b0;
    idle(3);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;
    idle(2);
    chk("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);

    // Exact write and release timing; checksum 13^93^10 = 0x90.
    exp_wq.push_back({6'd0, 32'h0000_0013}); exp_mem[0] = 32'h0000_0013;
    exp_wq.push_back({6'd1, 32'h0010_0093}); exp_mem[1] = 32'h0010_0093;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    chk("t1_we_before", 32'(imem_we), 32'd0);
    send_byte(8'h00);
    chk("t1_we_w0", 32'(imem_we), 32'd1);
    chk("t1_waddr_w0", 32'(imem_waddr), 32'd0);
    chk("t1_wdata_w0", imem_wdata, 32'h0000_0013);
    chk("t1_wl_w0", 32'(words_loaded), 32'd1);
    send_byte(8'h93);
    chk("t1_we_pulse", 32'(imem_we), 32'd0);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("t1_waddr_w1", 32'(imem_waddr), 32'd1);
    chk("t1_wdata_w1", imem_wdata, 32'h0010_0093);
    chk("t1_cpu_reset_csum", 32'(cpu_reset), 32'd1);
    send_byte(8'h90);
    check_status("t1", 1'b1, 1'b0, 2);

    // SYNC in DONE is ignored; boot_req beats a same-cycle SYNC.
    send_byte(8'hA5);
    chk("done_sync_ignored", 32'(load_done), 32'd1);
    rx_valid = 1'b1; rx_data = 8'hA5; boot_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; boot_req = 1'b0;
    chk("bootreq_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bootreq_load_done", 32'(load_done), 32'd0);
    w0 = writes_seen;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h44);
    idle(2);
    chk("bootreq_sync_dropped_done", 32'(load_done), 32'd0);
    chk("bootreq_sync_dropped_writes", 32'(writes_seen - w0), 32'd0);

    // Timeout: a byte on the 16th idle cycle saves the frame, 16 idle cycles kill it.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(TMO - 1);
    chk("tmo_near_err", 32'(load_err), 32'd0);
    send_byte(8'hCC);
    chk("tmo_saved_err", 32'(load_err), 32'd0);
    idle(TMO);
    chk("tmo_err", 32'(load_err), 32'd1);
    chk("tmo_cpu_reset", 32'(cpu_reset), 32'd1);
    idle(3);
    chk("err_held", 32'(load_err), 32'd1);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    chk("idle_bootreq_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h12);
    chk("err_held_nonsync", 32'(load_err), 32'd1);
    send_byte(8'hA5);
    chk("err_cleared_sync", 32'(load_err), 32'd0);
    idle(TMO + 4);
    chk("tmo_len0_err", 32'(load_err), 32'd1);

    // Reset in the middle of DATA after one word is written.
    exp_wq.push_back({6'd0, 32'h0403_0201}); exp_mem[0] = 32'h0403_0201;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    chk("mid_wl", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_wl", 32'(words_loaded), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk("mid_rst_stays", 32'(cpu_reset), 32'd1);

    for (int v = 0; v < 9; v++) begin
      words_q = {};
      for (int i = 0; i < vecs[v].len && i < DEPTH; i++) begin
        words_q.push_back(vecs[v].base + 32'(i) * vecs[v].step);
      end
      w0 = writes_seen;
      run_frame(vecs[v].len, vecs[v].use_cs, vecs[v].cs, 8'd0, 2, d_done, d_err, d_wl);
      check_status($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err, vecs[v].e_wl);
      chk($sformatf("vec%0d_writes", v), 32'(writes_seen - w0), 32'(vecs[v].e_wl));
      if (vecs[v].e_done) release_core($sformatf("vec%0d", v));
    end

    noise_en = 1'b1;
    for (int f = 0; f < 25; f++) begin
      len = ($urandom_range(0, 9) == 0) ? 64 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 6));
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      words_q = {};
      for (int i = 0; i < len && i < DEPTH; i++) words_q.push_back($urandom);
      w0 = writes_seen;
      run_frame(len, 1'b0, 8'd0, cx, 3, e_done, e_err, e_wl);
      check_status($sformatf("rnd%0d", f), e_done, e_err, e_wl);
      chk($sformatf("rnd%0d_writes", f), 32'(writes_seen - w0), 32'(e_wl));
      if (e_done) release_core($sformatf("rnd%0d", f));
    end
    noise_en = 1'b0;

    idle(2);
    chk("we_overlap_cpu_run", 32'(overlap), 32'd0);
    chk("pending_writes", 32'(exp_wq.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("mem%0d", i), act_mem[i], exp_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
